uart_tx_port: RTL and testbench

Memory-mapped UART transmitter on the 8-bit CPU data bus, downstream of the CPU core: the CPU stores bytes to a data address, the block queues them in a small FIFO and serialises them as 8N1 frames on `tx`. A status address lets CPU programs poll for space, overflow and line activity. One clock domain, shared with the CPU.

---
 rtl/uart_tx_port.sv | 94 +++++++++
 tb/tb_uart_tx_port.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_port.sv
// uart_tx_port: memory-mapped 8N1 UART transmitter with a small transmit FIFO
// and a pollable status register on the 8-bit CPU bus.
module uart_tx_port #(
   parameter int          CLKS_PER_BIT = 16,
   parameter int          FIFO_DEPTH   = 4,
   parameter logic [7:0]  DATA_ADDR    = 8'hF0,
   parameter logic [7:0]  STAT_ADDR    = 8'hF1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] addr,
   input  logic       wr_en,
   input  logic       rd_en,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       tx,
   output logic       busy
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wp, rp;
   logic [CW-1:0] count;
   logic          ovf, full, empty, push, pop, last, rd_stat, busy_c;
   state_t        state, state_n;
   logic [7:0]    baud, baud_n, shift, shift_n, status;
   logic [2:0]    bit_idx, bit_n;
   assign full    = count == CW'(FIFO_DEPTH);
   assign empty   = count == '0;
   assign push    = wr_en && addr == DATA_ADDR && !full;
   assign rd_stat = rd_en && addr == STAT_ADDR;
   assign last    = baud == 8'(CLKS_PER_BIT - 1);
   assign busy_c  = state != IDLE || !empty;
   assign status  = {4'b0, ovf, busy_c, empty, full};
   always_comb begin
      state_n = state;
      bit_n   = bit_idx;
      shift_n = shift;
      pop     = 1'b0;
      baud_n  = (state == IDLE || last) ? 8'd0 : baud + 8'd1;
      case (state)
         IDLE: if (!empty) begin
            pop     = 1'b1;
            shift_n = mem[rp];
            state_n = START;
         end
         START: if (last) begin
            state_n = DATA;
            bit_n   = 3'd0;
         end
         DATA: if (last) begin
            shift_n = shift >> 1;
            bit_n   = bit_idx + 3'd1;
            state_n = bit_idx == 3'd7 ? STOP : DATA;
         end
         default: if (last) begin
            pop     = !empty;
            shift_n = empty ? shift : mem[rp];
            state_n = empty ? IDLE : START;
         end
      endcase
   end
   // tx and busy are registered from the current state, so the line lags the
   // FSM by one cycle and busy stays high through the final stop-bit cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         baud    <= '0;
         bit_idx <= '0;
         shift   <= '0;
         wp      <= '0;
         rp      <= '0;
         count   <= '0;
         ovf     <= 1'b0;
         rdata   <= 8'h00;
         tx      <= 1'b1;
         busy    <= 1'b0;
      end else begin
         state   <= state_n;
         baud    <= baud_n;
         bit_idx <= bit_n;
         shift   <= shift_n;
         if (push) mem[wp] <= wdata;
         wp      <= push ? wp + AW'(1) : wp;
         rp      <= pop ? rp + AW'(1) : rp;
         count   <= count + CW'(push) - CW'(pop);
         ovf     <= (ovf && !rd_stat) || (wr_en && addr == DATA_ADDR && full);
         rdata   <= rd_en ? (rd_stat ? status : 8'h00) : rdata;
         tx      <= state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
         busy    <= busy_c;
      end
   end
endmodule

// File: tb/tb_uart_tx_port.sv
// tb_uart_tx_port: directed, table-driven bench for uart_tx_port with
// CLKS_PER_BIT=4 and FIFO_DEPTH=4.
module tb_uart_tx_port;
   logic       clk = 1'b0;
   logic       rst, wr_en, rd_en, tx, busy;
   logic [7:0] addr, wdata, rdata;
   int         checks = 0;
   int         errors = 0;
   int         falls = 0;
   logic       tx_prev = 1'b1;

   uart_tx_port #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .DATA_ADDR(8'hF0), .STAT_ADDR(8'hF1)) dut (
      .clk(clk), .rst(rst), .addr(addr), .wr_en(wr_en), .rd_en(rd_en),
      .wdata(wdata), .rdata(rdata), .tx(tx), .busy(busy)
   );

   always #5 clk = ~clk;

   // Counts start bits when the data bytes contain no 1->0 transitions.
   always @(negedge clk) begin
      if (tx_prev && !tx) falls++;
      tx_prev = tx;
   end

   typedef struct {
      logic       w;
      logic       r;
      logic [7:0] a;
      logic [7:0] d;
      logic [7:0] exp_rdata;
   } vec_t;
   vec_t vecs[8];

   task automatic check(input string name, input logic [39:0] got, input logic [39:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      addr = a; wdata = d; wr_en = 1'b1;
      cyc();
      wr_en = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a);
      addr = a; rd_en = 1'b1;
      cyc();
      rd_en = 1'b0;
   endtask

   // Called in the first start-bit cycle; returns one cycle after the stop bit.
   task automatic frame(input string name, input logic [7:0] b);
      logic [39:0] got, exp;
      logic [9:0]  bits;
      logic        lb;
      bits = {1'b1, b, 1'b0};
      lb = 1'b0;
      for (int c = 0; c < 40; c++) begin
         exp[c] = bits[c / 4];
         got[c] = tx;
         if (c == 39) lb = busy;
         cyc();
      end
      check(name, got, exp);
      check({name, "_busy_last_stop"}, 40'(lb), 40'd1);
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 400 && busy; i++) cyc();
      check({name, "_idle_timeout"}, 40'(busy), 40'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
   endtask

   initial begin
      int f0;
      vecs[0] = '{1'b0, 1'b1, 8'hF1, 8'h00, 8'h02};
      vecs[1] = '{1'b1, 1'b0, 8'hF2, 8'h55, 8'h02};
      vecs[2] = '{1'b0, 1'b1, 8'hF0, 8'h00, 8'h00};
      vecs[3] = '{1'b0, 1'b1, 8'hF1, 8'h00, 8'h02};
      vecs[4] = '{1'b0, 1'b1, 8'h33, 8'h00, 8'h00};
      vecs[5] = '{1'b0, 1'b0, 8'hF1, 8'h00, 8'h00};
      vecs[6] = '{1'b0, 1'b1, 8'hF1, 8'h00, 8'h02};
      vecs[7] = '{1'b1, 1'b0, 8'hF3, 8'h00, 8'h02};
      rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; addr = 8'h00; wdata = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset_tx_busy_rdata", 40'({tx, busy, rdata}), 40'({1'b1, 1'b0, 8'h00}));

      f0 = falls;
      for (int i = 0; i < 8; i++) begin
         addr = vecs[i].a; wdata = vecs[i].d; wr_en = vecs[i].w; rd_en = vecs[i].r;
         cyc();
         wr_en = 1'b0; rd_en = 1'b0;
         check($sformatf("vec%0d", i), 40'({rdata, busy, tx}), 40'({vecs[i].exp_rdata, 1'b0, 1'b1}));
      end
      repeat (50) cyc();
      check("addr_decode_no_frame", 40'(falls - f0), 40'd0);

      wr(8'hF0, 8'hA5);
      check("single_tx_edge1", 40'(tx), 40'd1);
      cyc();
      check("single_tx_edge2", 40'(tx), 40'd1);
      cyc();
      frame("single_a5", 8'hA5);
      check("single_after", 40'({busy, tx}), 40'({1'b0, 1'b1}));

      wr(8'hF0, 8'h00);
      wr(8'hF0, 8'hFF);
      cyc();
      frame("b2b_00", 8'h00);
      frame("b2b_ff", 8'hFF);
      check("b2b_after", 40'({busy, tx}), 40'({1'b0, 1'b1}));

      f0 = falls;
      for (int i = 0; i < 6; i++) wr(8'hF0, 8'hFF);
      rd(8'hF1);
      check("ovf_status1", 40'(rdata), 40'h0D);
      rd(8'hF1);
      check("ovf_status2", 40'(rdata), 40'h05);
      wait_idle("ovf");
      check("ovf_frames", 40'(falls - f0), 40'd5);
      rd(8'hF1);
      check("ovf_status_idle", 40'(rdata), 40'h02);

      wr(8'hF0, 8'h3C);
      repeat (18) cyc();
      check("mid_3c_bit3", 40'(tx), 40'd1);
      do_reset();
      check("mid_3c_after_rst", 40'({tx, busy}), 40'({1'b1, 1'b0}));
      rd(8'hF1);
      check("mid_3c_status", 40'(rdata), 40'h02);
      f0 = falls;
      repeat (60) cyc();
      check("mid_3c_no_frames", 40'({falls - f0, tx}), 40'({32'd0, 1'b1}));

      wr(8'hF0, 8'h00);
      wr(8'hF0, 8'h00);
      repeat (17) cyc();
      check("mid_00_bit3", 40'(tx), 40'd0);
      do_reset();
      check("mid_00_after_rst", 40'({tx, busy}), 40'({1'b1, 1'b0}));
      rd(8'hF1);
      check("mid_00_status", 40'(rdata), 40'h02);
      f0 = falls;
      repeat (60) cyc();
      check("mid_00_no_frames", 40'({falls - f0, tx}), 40'({32'd0, 1'b1}));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
